// File: rtl/fft_pkg.sv
// Shared constants and encodings for the FFT input loader.
// Holds frame geometry, RAM geometry, owner-select codes and FSM states.
package fft_pkg;

    localparam int N_POINTS = 1024;
    localparam int HALF     = N_POINTS / 2;
    localparam int CNT_W    = $clog2(N_POINTS);
    localparam int ADDR_W   = 11;
    localparam int RAM_DW   = 32;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        SEL_LOAD = 2'd0,
        SEL_FFT  = 2'd1,
        SEL_READ = 2'd2
    } sel_e;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        FLUSHWR  = 3'd1,
        START    = 3'd2,
        WAIT_FFT = 3'd3,
        HOLD     = 3'd4
    } state_e;

endpackage

// File: rtl/fft_in_loader_if.sv
// Sample stream into the FFT input loader.
// A sample moves when in_valid and in_ready are both high.
interface fft_in_loader_if #(
    parameter int DATA_W = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              in_last;

    modport master (
        output in_valid, in_re, in_im, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last,
        output in_ready
    );

endinterface

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of a sample counter.
// Produces decimation-in-time input order for the FFT RAM.
module fft_bitrev #(
    parameter int W = 10
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign dout[i] = din[W-1-i];
    end

endmodule

// File: rtl/fft_in_loader.sv
// Loads one FFT frame into two bank RAMs, then hands them to the engine.
// FFT_LOADER_BITREV_EN selects bit-reversed write order.
module fft_in_loader #(
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int DATA_W   = fft_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fft_in_loader_if.slave            s,
    input  logic                      flush,
    output logic                      ce0,
    output logic                      oce0,
    output logic                      wre0,
    output logic [fft_pkg::ADDR_W-1:0] ad0,
    output logic [2*DATA_W-1:0]       din0,
    output logic                      ce1,
    output logic                      oce1,
    output logic                      wre1,
    output logic [fft_pkg::ADDR_W-1:0] ad1,
    output logic [2*DATA_W-1:0]       din1,
    output logic                      fft_start,
    input  logic                      fft_finish,
    output logic [1:0]                sel,
    input  logic                      results_release,
    output logic                      results_valid,
    output logic                      frame_err
);

    import fft_pkg::*;

    localparam int CW = $clog2(N_POINTS);

    state_e                 state;
    state_e                 state_nx;
    sel_e                   sel_c;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          idx;
    logic                   rdy_q;
    logic                   xfer;
    logic                   wr;
    logic                   bank;
    logic                   cnt_last;
    logic [ADDR_W-1:0]      addr;
    logic [2*DATA_W-1:0]    wdata;

`ifdef FFT_LOADER_BITREV_EN
    fft_bitrev #(
        .W(CW)
    ) u_bitrev (
        .din (cnt),
        .dout(idx)
    );
`else
    assign idx = cnt;
`endif

    assign s.in_ready = rdy_q;
    assign xfer       = s.in_valid && rdy_q;
    assign wr         = xfer && !flush && (state == LOAD);
    assign cnt_last   = (cnt == CW'(N_POINTS - 1));
    assign bank       = idx[CW-1];
    assign addr       = ADDR_W'(idx[CW-2:0]);
    assign wdata      = {s.in_re, s.in_im};
    assign fft_start  = (state == START);
    assign wre0       = ce0;
    assign wre1       = ce1;
    assign oce0       = 1'b0;
    assign oce1       = 1'b0;
    assign sel        = sel_c;

    // Next state: frame fill, last write, start pulse, engine run, hold.
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:     if (wr && cnt_last) state_nx = FLUSHWR;
            FLUSHWR:  state_nx = START;
            START:    state_nx = WAIT_FFT;
            WAIT_FFT: if (fft_finish) state_nx = HOLD;
            HOLD:     if (results_release) state_nx = LOAD;
            default:  state_nx = LOAD;
        endcase
    end

    // RAM owner follows the current phase.
    always_comb begin
        sel_c = SEL_LOAD;
        unique case (1'b1)
            (state == HOLD):                          sel_c = SEL_READ;
            (state == START) || (state == WAIT_FFT):  sel_c = SEL_FFT;
            default:                                  sel_c = SEL_LOAD;
        endcase
    end

    // State register; ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == LOAD);
        end
    end

    // Sample counter; flush restarts the frame and drops the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            if (flush) begin
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered write strobes to whichever bank owns the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce0  <= 1'b0;
            ce1  <= 1'b0;
            ad0  <= '0;
            ad1  <= '0;
            din0 <= '0;
            din1 <= '0;
        end else begin
            ce0 <= wr && !bank;
            ce1 <= wr && bank;
            if (wr && !bank) begin
                ad0  <= addr;
                din0 <= wdata;
            end
            if (wr && bank) begin
                ad1  <= addr;
                din1 <= wdata;
            end
        end
    end

    // Completion pulse and sticky framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            results_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            results_valid <= (state == WAIT_FFT) && fft_finish;
            if (wr && (s.in_last != cnt_last)) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_in_loader.sv
// Self-checking bench for fft_in_loader.
// Honours FFT_LOADER_BITREV_EN to pick the expected write order.
module tb_fft_in_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        fft_finish = 1'b0;
    logic        results_release = 1'b0;
    logic        ce0, oce0, wre0, ce1, oce1, wre1;
    logic [10:0] ad0, ad1;
    logic [31:0] din0, din1;
    logic        fft_start, results_valid, frame_err;
    logic [1:0]  sel;

    fft_in_loader_if #(.DATA_W(16)) bus ();

    fft_in_loader #(
        .N_POINTS(1024),
        .DATA_W  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s              (bus),
        .flush          (flush),
        .ce0            (ce0),
        .oce0           (oce0),
        .wre0           (wre0),
        .ad0            (ad0),
        .din0           (din0),
        .ce1            (ce1),
        .oce1           (oce1),
        .wre1           (wre1),
        .ad1            (ad1),
        .din1           (din1),
        .fft_start      (fft_start),
        .fft_finish     (fft_finish),
        .sel            (sel),
        .results_release(results_release),
        .results_valid  (results_valid),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] act_mem [1024];
    logic [31:0] exp_mem [1024];
    int          wr_count = 0;
    int          bad_wr = 0;
    int          exp_cnt = 0;
    int          exp_wr = 0;
    logic        exp_err = 1'b0;
    logic [15:0] last_re, last_im;

    // Expected RAM index of the k-th sample of a frame.
    function automatic int map_idx(input int k);
`ifdef FFT_LOADER_BITREV_EN
        int r;
        int v;
        r = 0;
        v = k;
        for (int b = 0; b < 10; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
`else
        return k;
`endif
    endfunction

    // Capture every RAM write the loader issues.
    always @(negedge clk) begin
        if (ce0 && wre0) act_mem[{1'b0, ad0[8:0]}] <= din0;
        if (ce1 && wre1) act_mem[{1'b1, ad1[8:0]}] <= din1;
        wr_count <= wr_count + int'(ce0 && wre0) + int'(ce1 && wre1);
        if (((ce0 || ce1) && sel != 2'd0) || oce0 || oce1 ||
            (ce0 && ad0[10:9] != 2'b00) || (ce1 && ad1[10:9] != 2'b00))
            bad_wr <= bad_wr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample until accepted; update the reference model.
    task automatic send(input logic [15:0] re, input logic [15:0] im,
                        input logic last, input logic fl, input bit rnd);
        bit done;
        int guard;
        done = 0;
        guard = 0;
        while (!done) begin
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_re = re;
            bus.in_im = im;
            bus.in_last = last;
            flush = fl && bus.in_valid;
            done = bus.in_valid && bus.in_ready;
            tick();
            if (!done) begin
                guard++;
                if (guard > 64) begin
                    chk("send_ready_timeout", 64'(bus.in_ready), 64'(1));
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        flush = 1'b0;
        if (done) begin
            if (fl) begin
                exp_cnt = 0;
            end else begin
                exp_mem[map_idx(exp_cnt)] = {re, im};
                exp_wr++;
                if (last != (exp_cnt == 1023)) exp_err = 1'b1;
                exp_cnt = (exp_cnt + 1) % 1024;
                last_re = re;
                last_im = im;
            end
        end
    endtask

    // Called one cycle after the final transfer of a frame.
    task automatic end_frame();
        int mism;
        chk("last_wr_ce1", 64'(ce1), 64'(1));
        chk("last_wr_ad1", 64'(ad1), 64'(map_idx(1023) - 512));
        chk("last_wr_din1", 64'(din1), 64'({last_re, last_im}));
        chk("flushwr_ready", 64'(bus.in_ready), 64'(0));
        chk("flushwr_start", 64'(fft_start), 64'(0));
        tick();
        chk("start_pulse", 64'(fft_start), 64'(1));
        chk("start_sel", 64'(sel), 64'(1));
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        flush = 1'b1;
        results_release = 1'b1;
        chk("start_single", 64'(fft_start), 64'(0));
        chk("wait_sel", 64'(sel), 64'(1));
        tick();
        flush = 1'b0;
        results_release = 1'b0;
        chk("finish_ignored_rv", 64'(results_valid), 64'(0));
        chk("finish_ignored_sel", 64'(sel), 64'(1));
        chk("wait_ready", 64'(bus.in_ready), 64'(0));
        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (act_mem[i] !== exp_mem[i]) mism++;
        chk("ram_contents", 64'(mism), 64'(0));
        chk("write_count", 64'(wr_count), 64'(exp_wr));
        chk("bad_writes", 64'(bad_wr), 64'(0));
    endtask

    // Engine runs ~100 cycles, then the reader holds and releases.
    task automatic run_fft();
        int bad;
        bad = 0;
        repeat (100) begin
            tick();
            if (sel !== 2'd1 || bus.in_ready !== 1'b0 || results_valid !== 1'b0)
                bad++;
        end
        chk("wait_100", 64'(bad), 64'(0));
        fft_finish = 1'b1;
        tick();
        fft_finish = 1'b0;
        chk("results_valid", 64'(results_valid), 64'(1));
        chk("hold_sel", 64'(sel), 64'(2));
        bad = 0;
        repeat (6) begin
            tick();
            if (sel !== 2'd2 || bus.in_ready !== 1'b0 || results_valid !== 1'b0)
                bad++;
        end
        chk("hold_steady", 64'(bad), 64'(0));
        results_release = 1'b1;
        tick();
        results_release = 1'b0;
        chk("release_sel", 64'(sel), 64'(0));
        chk("release_ready", 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        int wc0;
        logic [15:0] r, m;
        bus.in_valid = 1'b0;
        bus.in_re = '0;
        bus.in_im = '0;
        bus.in_last = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            act_mem[i] = '0;
            exp_mem[i] = '0;
        end

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        chk("rst_strobes", 64'({ce0, oce0, wre0, ce1, oce1, wre1}), 64'(0));
        chk("rst_flags", 64'({fft_start, results_valid, frame_err}), 64'(0));
        chk("rst_bus", 64'({ad0, ad1, din0, din1}), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(bus.in_ready), 64'(1));

        // Frame 1: ramp data, random valid gaps.
        for (int k = 0; k < 1024; k++)
            send(16'(k), 16'(-k), k == 1023, 1'b0, 1'b1);
        end_frame();
`ifdef FFT_LOADER_BITREV_EN
        chk("bitrev_k1", 64'(act_mem[512]), 64'(32'h0001FFFF));
        chk("bitrev_k2", 64'(act_mem[256]), 64'(32'h0002FFFE));
        chk("bitrev_k1023", 64'(act_mem[1023]), 64'(32'h03FFFC01));
`else
        chk("nat_fft0_ad5", 64'(act_mem[5]), 64'(32'h0005FFFB));
        chk("nat_fft1_ad0", 64'(act_mem[512]), 64'(32'h0200FE00));
`endif
        chk("frame1_err", 64'(frame_err), 64'(exp_err));
        run_fft();

        // Frame 2: random data, flush after 300 samples.
        for (int k = 0; k < 300; k++) begin
            if (k == 100) results_release = 1'b1;
            send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
            results_release = 1'b0;
        end
        repeat (2) tick();
        wc0 = wr_count;
        send(16'hDEAD, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        chk("flush_no_write", 64'(wr_count), 64'(wc0));
        r = 16'($urandom);
        m = 16'($urandom);
        send(r, m, 1'b0, 1'b0, 1'b0);
        tick();
        chk("flush_idx0", 64'(act_mem[map_idx(0)]), 64'({r, m}));
        chk("flush_wcount", 64'(wr_count), 64'(wc0 + 1));
        for (int k = 1; k < 1024; k++)
            send(16'($urandom), 16'($urandom), k == 1023, 1'b0, 1'b1);
        end_frame();
        chk("frame2_err", 64'(frame_err), 64'(0));
        run_fft();

        // Frame 3: in_last misplaced on sample 1000.
        for (int k = 0; k < 1024; k++) begin
            send(16'($urandom), 16'($urandom), k == 1000, 1'b0, 1'b1);
            if (k == 999) chk("err_before", 64'(frame_err), 64'(0));
            if (k == 1000) chk("err_set", 64'(frame_err), 64'(1));
        end
        end_frame();
        chk("frame3_err", 64'(frame_err), 64'(exp_err));

        // Reset in the middle of the FFT run.
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 64'(sel), 64'(0));
        chk("midrst_ready", 64'(bus.in_ready), 64'(0));
        chk("midrst_flags", 64'({fft_start, results_valid, frame_err}), 64'(0));
        chk("midrst_strobes", 64'({ce0, oce0, wre0, ce1, oce1, wre1}), 64'(0));
        chk("midrst_bus", 64'({ad0, ad1, din0, din1}), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        tick();
        chk("after_rst_ready", 64'(bus.in_ready), 64'(1));
        chk("after_rst_sel", 64'(sel), 64'(0));
        for (int k = 0; k < 3; k++)
            send(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++)
            chk("after_rst_data", 64'(act_mem[map_idx(k)]),
                64'(exp_mem[map_idx(k)]));
        chk("after_rst_err", 64'(frame_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
